// File: rtl/cmp_swap_pipe.sv
// cmp_swap_pipe: two-stage per-lane compare-exchange pipeline with valid/ready flow control
module cmp_swap_pipe #(
    parameter int    DATA_WIDTH = 64,
    parameter int    CHANNELS   = 4,
    parameter string COM_STYLE  = "UP",
    parameter int    SIGNED     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_data0,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_data1,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_data0,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_data1,
    output logic [CHANNELS-1:0]            m_swap,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [31:0]                    swap_count
);
    localparam int W = CHANNELS * DATA_WIDTH;
    localparam bit DOWN = (COM_STYLE == "DOWN");
    // flipping the sign bit turns a two's-complement compare into an unsigned one
    localparam logic [DATA_WIDTH-1:0] BIAS = (SIGNED != 0) ? (DATA_WIDTH'(1) << (DATA_WIDTH - 1)) : '0;

    logic                v1_q, v2_q;
    logic [W-1:0]        a_q, b_q, d0_q, d1_q, d0_d, d1_d;
    logic [CHANNELS-1:0] sw_q, sw_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [32:0]         sum;
    logic                adv2;

    assign adv2    = !v2_q || m_ready;
    assign s_ready = !rst && (!v1_q || adv2);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] a, b, ak, bk;
        assign a        = a_q[g*DATA_WIDTH +: DATA_WIDTH];
        assign b        = b_q[g*DATA_WIDTH +: DATA_WIDTH];
        assign ak       = a ^ BIAS;
        assign bk       = b ^ BIAS;
        assign sw_d[g]  = DOWN ? (ak < bk) : (ak > bk);
        assign d0_d[g*DATA_WIDTH +: DATA_WIDTH] = sw_d[g] ? b : a;
        assign d1_d[g*DATA_WIDTH +: DATA_WIDTH] = sw_d[g] ? a : b;
    end

    // saturating accumulation of swapped lanes on each delivered beat
    always_comb begin
        sum   = {1'b0, cnt_q} + 33'($countones(sw_q));
        cnt_d = (v2_q && m_ready) ? (sum[32] ? 32'hFFFF_FFFF : sum[31:0]) : cnt_q;
    end

    // stage 1: capture operands whenever the stage is free or draining
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (s_ready) begin
            v1_q <= s_valid;
            if (s_valid) begin
                a_q <= s_data0;
                b_q <= s_data1;
            end
        end
    end

    // stage 2: register compare-exchange result, hold while output is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
            d0_q <= '0;
            d1_q <= '0;
            sw_q <= '0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                d0_q <= d0_d;
                d1_q <= d1_d;
                sw_q <= sw_d;
            end
        end
    end

    // swap counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign m_data0    = d0_q;
    assign m_data1    = d1_q;
    assign m_swap     = sw_q;
    assign m_valid    = v2_q;
    assign swap_count = cnt_q;
endmodule

// File: doc/cmp_swap_pipe.md
CMP_SWAP_PIPE -- requirements
Module: cmp_swap_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of one compared word.
REQ-002 SHALL have parameter CHANNELS, default 4, legal range 1..16: number of independent compare-exchange lanes.
REQ-003 SHALL have parameter COM_STYLE, default "UP": "UP" means the smaller word goes to output 0; "DOWN" means the larger word goes to output 0.
REQ-004 SHALL have parameter SIGNED, default 0: 0 means unsigned compare; 1 means two's-complement compare.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port s_data0, input, CHANNELS*DATA_WIDTH bits: operand A; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port s_data1, input, CHANNELS*DATA_WIDTH bits: operand B, same lane packing.
REQ-009 SHALL have port s_valid, input, 1 bit: input beat valid.
REQ-010 SHALL have port s_ready, output, 1 bit: block accepts an input beat.
REQ-011 SHALL have port m_data0, output, CHANNELS*DATA_WIDTH bits: ordered result word 0 per lane.
REQ-012 SHALL have port m_data1, output, CHANNELS*DATA_WIDTH bits: ordered result word 1 per lane.
REQ-013 SHALL have port m_swap, output, CHANNELS bits: bit i is 1 if lane i operands were exchanged.
REQ-014 SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-015 SHALL have port m_ready, input, 1 bit: downstream accepts the output beat.
REQ-016 SHALL have port swap_count, output, 32 bits: saturating total of swapped lanes delivered.

Function
REQ-017 SHALL transfer an input beat when s_valid and s_ready are both 1 at a clock edge, and an output beat when m_valid and m_ready are both 1.
REQ-018 SHALL be a 2-stage pipeline: stage 1 registers the operands; stage 2 registers the compare/exchange result. Latency is 2 cycles from input transfer to m_valid when the pipeline is not stalled.
REQ-019 SHALL load a stage when it is empty or when its contents move forward in the same cycle; a full stage that cannot move SHALL hold its data unchanged.
REQ-020 SHALL drive s_ready = !stage1_valid || stage1 advancing. At m_ready=1 with continuous s_valid this gives one beat per cycle.
REQ-021 SHALL, in each lane with COM_STYLE "UP", set swap = (A > B); swap=1 outputs (B,A), swap=0 outputs (A,B).
REQ-022 SHALL, with COM_STYLE "DOWN", set swap = (A < B).
REQ-023 SHALL treat equal operands as no swap: m_swap bit is 0 and the order is preserved.
REQ-024 SHALL compare as signed when SIGNED=1, so for DATA_WIDTH=8, 0x80 < 0x7F.
REQ-025 SHALL compute each lane independently; no cross-lane ordering.
REQ-026 SHALL keep m_data0, m_data1 and m_swap stable while m_valid=1 and m_ready=0.
REQ-027 SHALL, on each output transfer, add popcount(m_swap) to swap_count, saturating at 0xFFFFFFFF and never wrapping.
REQ-028 SHALL not drop, duplicate or reorder beats under any s_valid/m_ready pattern.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear both stage valid flags, m_valid, m_data0, m_data1, m_swap and swap_count to 0.
REQ-030 SHALL hold s_ready at 0 while rst=1.
REQ-031 SHALL discard any beat in flight when reset is asserted mid-operation; the first post-reset output is the first beat accepted after reset.

Verification
REQ-032 Bench SHALL cover basic UP (CHANNELS=4, DATA_WIDTH=64): lanes A={5,9,3,3}, B={7,2,3,1} -> 2 cycles later m_data0={5,2,3,1}, m_data1={7,9,3,3}, m_swap=4'b1010, swap_count=2.
REQ-033 Bench SHALL cover DOWN with SIGNED=1 (DATA_WIDTH=8): A=0x80, B=0x7F -> m_data0=0x7F, m_data1=0x80, m_swap=1.
REQ-034 Bench SHALL cover backpressure: stream 6 beats with m_ready=0 for cycles 3..7 -> s_ready falls after 2 beats are held, outputs stay stable, and all 6 beats arrive in order with no loss.
REQ-035 Bench SHALL cover throughput: continuous s_valid and m_ready=1 for 100 beats -> 100 outputs in 101 cycles after the first accept, one per cycle.
REQ-036 Bench SHALL cover saturation: preload swap_count to 0xFFFFFFFE via traffic (or force), then send a beat with 4 swaps -> swap_count=0xFFFFFFFF and stays there.
REQ-037 Bench SHALL cover reset mid-stream: assert rst for 1 cycle with both stages full -> m_valid=0 and swap_count=0 the next cycle, and no stale beat ever appears.
